seq_step_engine: RTL and testbench
==================================

# seq_step_engine

Synthesizable sequence engine that drives four 8-bit result registers `a`, `b`, `c`, `d` from a small loadable step program, with one step executed per clock. It is the producing end of the result-check flow: the self-checking benches sample `a`..`d` after a fixed number of cycles, and this block generates those values. It sits under `top` as the sequential core and exposes a start/busy/done handshake plus a program-load port.

## Interface
- `DEPTH`, 16: number of program entries; must be a power of two, minimum 2.
- `MAX_STEPS`, 256: step limit used only when the watchdog is compiled in.
- `PC_W`: localparam, clog2(DEPTH); not overridable.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `prog_we`  in  1  program write strobe.
- `prog_addr`  in  PC_W  program write address.
- `prog_data`  in  16  program word.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  sticky watchdog abort flag; cleared by the next accepted `start`.
- `a`, `b`, `c`, `d`  out  8 each  result registers; register index 0..3 in that order.

## Operation
- Word fields: [15:13] op, [12:11] dst, [10:9] src, [8] reserved (write 0, ignored), [7:0] imm.
- Opcodes:
  - 0 NOP
  - 1 LDI: dst=imm
  - 2 MOV: dst=src
  - 3 ADD: dst=dst+src
  - 4 SUB: dst=dst-src
  - 5 ADDI: dst=dst+imm
  - 6 JNZ: if src!=0 then pc=imm[PC_W-1:0], else pc+1
  - 7 HALT
- Arithmetic is modulo 256; carry and borrow are discarded. When dst==src, ADD doubles the register and SUB clears it.
- FSM has two states, IDLE and RUN.
  - IDLE with `start`: clear `a`..`d` and `err`, set pc=0, enter RUN.
  - RUN executes mem[pc] each cycle.
  - HALT: go to IDLE and pulse `done`; registers are not modified.
  - If a non-JNZ instruction that is not HALT executes at pc==DEPTH-1, that instruction completes, then the block behaves as an implicit HALT on the same edge (IDLE plus `done`). There is no pc wrap.
- `prog_we` is honoured only in IDLE; writes in RUN are dropped. A write and a `start` in the same IDLE cycle: the write lands first and the run sees the new word.
- `start` in RUN is ignored.
- Program memory is not reset. All other state is reset.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `a`=`b`=`c`=`d`=0, state IDLE, pc=0.
- `start` sampled at edge k: `busy` is high from k. The instruction at pc 0 executes at edge k+1. Instruction n, counted without jumps, executes at edge k+1+n.
- HALT at edge h: `busy` low and `done` high for cycle h..h+1 only.
- Outputs update on the edge that executes the instruction; there is no extra output latency.
- An asserted `rst` mid-run clears everything immediately, with no `done`. The program is retained.

## Configuration
- `SEQ_WDOG_EN` defined: a step counter counts executed instructions per run. When the count reaches `MAX_STEPS` without a HALT, the block returns to IDLE, sets `err`, and issues no `done`. `a`..`d` hold their last values.
- `SEQ_WDOG_EN` undefined: there is no counter, `err` is tied 0, and an infinite JNZ loop runs until reset.

## Structure
- Package `seq_pkg` holds:
  - the opcode enum and field bit positions
  - the FSM state enum
  - the register index constants A=0..D=3
- Sub-module `seq_prog_mem` provides DEPTH×16 storage with a synchronous write and a combinational read of mem[pc].

## Test plan
- Program {LDI a,14; LDI d,1; HALT}, then `start` at edge 0: at edge 3 `done`=1 and `a`=14, `b`=0, `c`=0, `d`=1. After edge 4, `busy`=0 and `done`=0.
- Program {LDI a,200; LDI b,100; ADD a,b; SUB c,b; HALT}: `a`=44 (wrap), `b`=100, `c`=156, `done` at edge 5.
- Loop program {LDI a,3; ADDI b,2; ADDI a,255; JNZ a→1; HALT}: final `a`=0, `b`=6, `done` at edge 11.
- `rst` low for one cycle during step 2 of the first test: all outputs 0 at once and no `done`. A following `start` reruns to `a`=14, `d`=1.
- `prog_we` and `start` asserted while busy: no effect on the current run or on memory. 16 NOPs with no HALT gives an implicit halt at edge 16.
- With `SEQ_WDOG_EN` and `MAX_STEPS`=8, program {JNZ a→0} after {LDI a,1}: `err`=1 and IDLE after 8 steps, with no `done`. The next `start` clears `err`.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the step sequencer: opcodes, instruction field positions,
// FSM states and result-register indices.
package seq_pkg;

    localparam int WORD_W  = 16;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int DST_HI  = 12;
    localparam int DST_LO  = 11;
    localparam int SRC_HI  = 10;
    localparam int SRC_LO  = 9;
    localparam int RSV_BIT = 8;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDI  = 3'd1,
        OP_MOV  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_ADDI = 3'd5,
        OP_JNZ  = 3'd6,
        OP_HALT = 3'd7
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_B = 2'd1;
    localparam logic [1:0] REG_C = 2'd2;
    localparam logic [1:0] REG_D = 2'd3;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x 16 words, synchronous write, combinational read.
// Contents are intentionally not reset so a program survives a reset.
module seq_prog_mem
    import seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PC_W-1:0]   waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [PC_W-1:0]   raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Program word write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/seq_step_engine.sv
// One-instruction-per-clock sequencer driving four 8-bit result registers.
// Optional step watchdog: define SEQ_WDOG_EN to abort runs after MAX_STEPS steps.
module seq_step_engine
    import seq_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int MAX_STEPS = 256,
    localparam int PC_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        a,
    output logic [7:0]        b,
    output logic [7:0]        c,
    output logic [7:0]        d
);

    state_e            state_r, state_n;
    logic [PC_W-1:0]   pc_r, pc_n;
    logic [3:0][7:0]   regs_r, regs_n;
    logic              busy_r, done_r, done_n, err_r, err_n;
    logic [WORD_W-1:0] instr_s;
    op_e               op_s;
    logic [1:0]        dst_s, src_s;
    logic [7:0]        imm_s, src_val_s, dst_val_s;
    logic              last_s, halt_s, mem_we_s, wdog_hit_s;
    logic              unused_rsv_s;

    // Writes are only honoured while idle so a running program never changes under itself
    assign mem_we_s = prog_we && (state_r == ST_IDLE);

    seq_prog_mem #(.DEPTH(DEPTH), .PC_W(PC_W)) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_r),
        .rdata (instr_s)
    );

    assign op_s         = op_e'(instr_s[OP_HI:OP_LO]);
    assign dst_s        = instr_s[DST_HI:DST_LO];
    assign src_s        = instr_s[SRC_HI:SRC_LO];
    assign imm_s        = instr_s[IMM_HI:IMM_LO];
    assign unused_rsv_s = instr_s[RSV_BIT];
    assign src_val_s    = regs_r[src_s];
    assign dst_val_s    = regs_r[dst_s];
    assign last_s       = (pc_r == PC_W'(DEPTH - 1));
    // Falling off the end of the program acts like HALT; JNZ is the only way past the last slot
    assign halt_s       = (op_s == OP_HALT) || ((op_s != OP_JNZ) && last_s);

`ifdef SEQ_WDOG_EN
    localparam int SC_W = $clog2(MAX_STEPS + 1);
    logic [SC_W-1:0] step_cnt_r, step_cnt_n;

    assign wdog_hit_s = (step_cnt_r == SC_W'(MAX_STEPS - 1));

    // Step counter next value: restarts on an accepted start, advances per executed step
    always_comb begin
        step_cnt_n = step_cnt_r;
        if ((state_r == ST_IDLE) && start) begin
            step_cnt_n = '0;
        end else if (state_r == ST_RUN) begin
            step_cnt_n = step_cnt_r + SC_W'(1);
        end else begin
            step_cnt_n = step_cnt_r;
        end
    end

    // Step counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_cnt_r <= '0;
        end else begin
            step_cnt_r <= step_cnt_n;
        end
    end
`else
    // No step limit exists without the watchdog; this can never fire for a legal MAX_STEPS
    assign wdog_hit_s = (MAX_STEPS < 0);
`endif

    // Next-state, program counter and datapath for one executed step
    always_comb begin
        state_n = state_r;
        pc_n    = pc_r;
        regs_n  = regs_r;
        done_n  = 1'b0;
        err_n   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    pc_n    = '0;
                    regs_n  = '0;
                    err_n   = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                case (op_s)
                    OP_LDI:  regs_n[dst_s] = imm_s;
                    OP_MOV:  regs_n[dst_s] = src_val_s;
                    OP_ADD:  regs_n[dst_s] = dst_val_s + src_val_s;
                    OP_SUB:  regs_n[dst_s] = dst_val_s - src_val_s;
                    OP_ADDI: regs_n[dst_s] = dst_val_s + imm_s;
                    default: regs_n = regs_r;
                endcase
                if ((op_s == OP_JNZ) && (src_val_s != 8'd0)) begin
                    pc_n = imm_s[PC_W-1:0];
                end else begin
                    pc_n = pc_r + PC_W'(1);
                end
                if (halt_s) begin
                    state_n = ST_IDLE;
                    pc_n    = '0;
                    done_n  = 1'b1;
                end else if (wdog_hit_s) begin
                    state_n = ST_IDLE;
                    pc_n    = '0;
                    err_n   = 1'b1;
                end else begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = ST_IDLE;
                pc_n    = '0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            pc_r    <= '0;
            regs_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            pc_r    <= pc_n;
            regs_r  <= regs_n;
            busy_r  <= (state_n == ST_RUN);
            done_r  <= done_n;
            err_r   <= err_n;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;
    assign a    = regs_r[REG_A];
    assign b    = regs_r[REG_B];
    assign c    = regs_r[REG_C];
    assign d    = regs_r[REG_D];

endmodule

// File: tb/tb_seq_step_engine.sv
// Directed, table-driven bench for seq_step_engine with hand-written corner sequences.
module tb_seq_step_engine;
    import seq_pkg::*;

    localparam int DEPTH = 16;

    typedef struct {
        logic [DEPTH-1:0][15:0] prog;
        int                     edge_n;
        logic [7:0]             ea, eb, ec, ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, prog_we, start;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic        busy, done, err;
    logic [7:0]  a, b, c, d;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs [4];

    always #5 clk = ~clk;

    seq_step_engine #(.DEPTH(DEPTH), .MAX_STEPS(8)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .busy(busy), .done(done),
        .err(err), .a(a), .b(b), .c(c), .d(d)
    );

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] dst,
                                        input logic [1:0] src, input logic [7:0] imm);
        return {op, dst, src, 1'b0, imm};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DEPTH-1:0][15:0] p);
        for (int i = 0; i < DEPTH; i++) begin
            prog_we   = 1'b1;
            prog_addr = i[3:0];
            prog_data = p[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    // start at edge 0, wait for done, compare timing and results
    task automatic run(input string tag, input int exp_edge, input logic [7:0] ea,
                       input logic [7:0] eb, input logic [7:0] ec, input logic [7:0] ed,
                       input bit poke);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        start = 1'b1;
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        chk({tag, " busy after start"}, int'(busy), 1);
        while (!got && n < 64) begin
            if (poke) begin
                prog_we   = 1'b1;
                prog_addr = 4'd2;
                prog_data = enc(OP_LDI, REG_B, REG_A, 8'd99);
                start     = 1'b1;
            end
            tick();
            n++;
            if (done) got = 1'b1;
        end
        prog_we = 1'b0;
        start   = 1'b0;
        chk({tag, " done edge"}, n, exp_edge);
        chk({tag, " busy at done"}, int'(busy), 0);
        chk({tag, " a"}, int'(a), int'(ea));
        chk({tag, " b"}, int'(b), int'(eb));
        chk({tag, " c"}, int'(c), int'(ec));
        chk({tag, " d"}, int'(d), int'(ed));
        chk({tag, " err"}, int'(err), 0);
        tick();
        chk({tag, " done one cycle"}, int'(done), 0);
        chk({tag, " idle after done"}, int'(busy), 0);
    endtask

    initial begin
        bit seen;
        logic [DEPTH-1:0][15:0] p;

        for (int v = 0; v < 4; v++) vecs[v].prog = '0;
        vecs[0].prog[0] = enc(OP_LDI, REG_A, REG_A, 8'd14);
        vecs[0].prog[1] = enc(OP_LDI, REG_D, REG_A, 8'd1);
        vecs[0].prog[2] = enc(OP_HALT, REG_A, REG_A, 8'd0);
        vecs[0].edge_n = 3;  vecs[0].ea = 8'd14; vecs[0].eb = 8'd0;
        vecs[0].ec = 8'd0;   vecs[0].ed = 8'd1;
        vecs[1].prog[0] = enc(OP_LDI, REG_A, REG_A, 8'd200);
        vecs[1].prog[1] = enc(OP_LDI, REG_B, REG_A, 8'd100);
        vecs[1].prog[2] = enc(OP_ADD, REG_A, REG_B, 8'd0);
        vecs[1].prog[3] = enc(OP_SUB, REG_C, REG_B, 8'd0);
        vecs[1].prog[4] = enc(OP_HALT, REG_A, REG_A, 8'd0);
        vecs[1].edge_n = 5;  vecs[1].ea = 8'd44; vecs[1].eb = 8'd100;
        vecs[1].ec = 8'd156; vecs[1].ed = 8'd0;
        vecs[2].prog[0] = enc(OP_LDI, REG_A, REG_A, 8'd3);
        vecs[2].prog[1] = enc(OP_ADDI, REG_B, REG_A, 8'd2);
        vecs[2].prog[2] = enc(OP_ADDI, REG_A, REG_A, 8'd255);
        vecs[2].prog[3] = enc(OP_JNZ, REG_A, REG_A, 8'd1);
        vecs[2].prog[4] = enc(OP_HALT, REG_A, REG_A, 8'd0);
        vecs[2].edge_n = 11; vecs[2].ea = 8'd0; vecs[2].eb = 8'd6;
        vecs[2].ec = 8'd0;   vecs[2].ed = 8'd0;
        vecs[3].prog[0] = enc(OP_LDI, REG_C, REG_A, 8'd77);
        vecs[3].prog[1] = enc(OP_MOV, REG_D, REG_C, 8'd0);
        vecs[3].prog[2] = enc(OP_ADD, REG_C, REG_C, 8'd0);
        vecs[3].prog[3] = enc(OP_LDI, REG_B, REG_A, 8'd5);
        vecs[3].prog[4] = enc(OP_SUB, REG_B, REG_B, 8'd0);
        vecs[3].prog[5] = enc(OP_LDI, REG_A, REG_A, 8'd250);
        vecs[3].prog[6] = enc(OP_ADDI, REG_A, REG_A, 8'd10);
        vecs[3].prog[7] = enc(OP_HALT, REG_A, REG_A, 8'd0);
        vecs[3].edge_n = 8;  vecs[3].ea = 8'd4; vecs[3].eb = 8'd0;
        vecs[3].ec = 8'd154; vecs[3].ed = 8'd77;

        rst = 1'b0; prog_we = 1'b0; start = 1'b0; prog_addr = 4'd0; prog_data = 16'd0;
        #2;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset regs", int'({a, b, c, d}), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            load(vecs[v].prog);
            run($sformatf("vec%0d", v), vecs[v].edge_n, vecs[v].ea, vecs[v].eb,
                vecs[v].ec, vecs[v].ed, 1'b0);
        end

        // reset during step 2 of the first program
        load(vecs[0].prog);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("midrst a before", int'(a), 14);
        #2 rst = 1'b0;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst regs", int'({a, b, c, d}), 0);
        chk("midrst done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        chk("midrst no done", int'(seen), 0);
        run("rerun", 3, 8'd14, 8'd0, 8'd0, 8'd1, 1'b0);

        // writes and start while busy are dropped
        run("poke", 3, 8'd14, 8'd0, 8'd0, 8'd1, 1'b1);
        run("after poke", 3, 8'd14, 8'd0, 8'd0, 8'd1, 1'b0);

        // write and start in the same idle cycle
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = enc(OP_LDI, REG_A, REG_A, 8'd55);
        run("wr+start", 3, 8'd55, 8'd0, 8'd0, 8'd1, 1'b0);

        // 16 NOPs: implicit halt at the last slot
        p = '0;
        load(p);
        run("implicit", 16, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);

        p = '0;
        p[0] = enc(OP_LDI, REG_A, REG_A, 8'd1);
        p[1] = enc(OP_JNZ, REG_A, REG_A, 8'd0);
        load(p);
`ifdef SEQ_WDOG_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (done) seen = 1'b1;
            if (i == 7) chk("wdog busy at 7", int'(busy), 1);
        end
        chk("wdog err", int'(err), 1);
        chk("wdog idle", int'(busy), 0);
        chk("wdog no done", int'(seen), 0);
        chk("wdog a held", int'(a), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wdog err cleared", int'(err), 0);
        for (int i = 0; i < 9; i++) tick();
        chk("wdog second abort", int'(err), 1);
`else
        start = 1'b1;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || !busy || err) seen = 1'b1;
        end
        chk("loop still running", int'(seen), 0);
        #2 rst = 1'b0;
        #1;
        chk("loop reset busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
